// File: rtl/dma_bus_arbiter.sv
// Round-robin arbiter sharing one TileLink-UL master port among NoC DMA channels.
// A requests are registered onto the shared port; D responses are steered back by source.
module dma_bus_arbiter #(
  parameter int NoC     = 2,
  parameter int TL_RS   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic               dma_clock_i,
  input  logic               dma_reset_i,
  input  logic [3*NoC-1:0]   s_a_opcode,
  input  logic [3*NoC-1:0]   s_a_param,
  input  logic [4*NoC-1:0]   s_a_size,
  input  logic [32*NoC-1:0]  s_a_address,
  input  logic [32*NoC-1:0]  s_a_data,
  input  logic [4*NoC-1:0]   s_a_mask,
  input  logic [NoC-1:0]     s_a_corrupt,
  input  logic [NoC-1:0]     s_a_valid,
  output logic [NoC-1:0]     s_a_ready,
  output logic [3*NoC-1:0]   s_d_opcode,
  output logic [2*NoC-1:0]   s_d_param,
  output logic [4*NoC-1:0]   s_d_size,
  output logic [32*NoC-1:0]  s_d_data,
  output logic [NoC-1:0]     s_d_denied,
  output logic [NoC-1:0]     s_d_corrupt,
  output logic [NoC-1:0]     s_d_valid,
  input  logic [NoC-1:0]     s_d_ready,
  output logic [2:0]         m_a_opcode,
  output logic [2:0]         m_a_param,
  output logic [3:0]         m_a_size,
  output logic [TL_RS-1:0]   m_a_source,
  output logic [31:0]        m_a_address,
  output logic [31:0]        m_a_data,
  output logic [3:0]         m_a_mask,
  output logic               m_a_corrupt,
  output logic               m_a_valid,
  input  logic               m_a_ready,
  input  logic [2:0]         m_d_opcode,
  input  logic [1:0]         m_d_param,
  input  logic [3:0]         m_d_size,
  input  logic [TL_RS-1:0]   m_d_source,
  input  logic [31:0]        m_d_data,
  input  logic               m_d_denied,
  input  logic               m_d_corrupt,
  input  logic               m_d_valid,
  output logic               m_d_ready,
  output logic               busy_o,
  output logic               drop_o
);

  localparam int PW = (NoC > 1) ? $clog2(NoC) : 1;

  logic [PW-1:0]  ptr;
  logic [3:0]     cnt [NoC];
  logic [NoC-1:0] elig;
  logic [NoC-1:0] grant;
  logic [NoC-1:0] src_hit;
  logic           src_known;
  logic           d_fire;
  logic           slot_free;
  logic           win_vld;
  logic [PW-1:0]  win;

  logic [2:0]  sel_opcode;
  logic [2:0]  sel_param;
  logic [3:0]  sel_size;
  logic [31:0] sel_address;
  logic [31:0] sel_data;
  logic [3:0]  sel_mask;
  logic        sel_corrupt;

  // Winner is the eligible channel closest to ptr going upward modulo NoC.
  always_comb begin
    int best;
    best      = NoC;
    slot_free = ~m_a_valid | m_a_ready;
    win_vld   = 1'b0;
    win       = '0;
    for (int i = 0; i < NoC; i++) begin
      elig[i] = s_a_valid[i] & (cnt[i] < 4'(MAX_OUT));
      if (elig[i] && (((i - int'(ptr) + NoC) % NoC) < best)) begin
        best    = (i - int'(ptr) + NoC) % NoC;
        win     = PW'(i);
        win_vld = 1'b1;
      end
    end
    for (int i = 0; i < NoC; i++) begin
      grant[i] = slot_free & win_vld & (win == PW'(i));
    end
  end

  assign s_a_ready = grant;

  always_comb begin
    sel_opcode  = '0;
    sel_param   = '0;
    sel_size    = '0;
    sel_address = '0;
    sel_data    = '0;
    sel_mask    = '0;
    sel_corrupt = 1'b0;
    for (int i = 0; i < NoC; i++) begin
      if (grant[i]) begin
        sel_opcode  = s_a_opcode[3*i +: 3];
        sel_param   = s_a_param[3*i +: 3];
        sel_size    = s_a_size[4*i +: 4];
        sel_address = s_a_address[32*i +: 32];
        sel_data    = s_a_data[32*i +: 32];
        sel_mask    = s_a_mask[4*i +: 4];
        sel_corrupt = s_a_corrupt[i];
      end
    end
  end

  // D steering: sources outside the channel range are accepted and discarded.
  always_comb begin
    for (int i = 0; i < NoC; i++) begin
      src_hit[i] = (m_d_source == TL_RS'(i));
    end
    src_known = |src_hit;
    m_d_ready = src_known ? |(src_hit & s_d_ready) : 1'b1;
    d_fire    = m_d_valid & m_d_ready;
  end

  assign s_d_valid   = {NoC{m_d_valid}} & src_hit;
  assign s_d_opcode  = {NoC{m_d_opcode}};
  assign s_d_param   = {NoC{m_d_param}};
  assign s_d_size    = {NoC{m_d_size}};
  assign s_d_data    = {NoC{m_d_data}};
  assign s_d_denied  = {NoC{m_d_denied}};
  assign s_d_corrupt = {NoC{m_d_corrupt}};

  always_comb begin
    busy_o = m_a_valid;
    for (int i = 0; i < NoC; i++) begin
      if (cnt[i] != 4'd0) busy_o = 1'b1;
    end
  end

  // Output slot stage
  always_ff @(posedge dma_clock_i) begin
    if (dma_reset_i) begin
      m_a_valid   <= 1'b0;
      m_a_opcode  <= '0;
      m_a_param   <= '0;
      m_a_size    <= '0;
      m_a_source  <= '0;
      m_a_address <= '0;
      m_a_data    <= '0;
      m_a_mask    <= '0;
      m_a_corrupt <= 1'b0;
      ptr         <= '0;
      drop_o      <= 1'b0;
    end else begin
      drop_o <= d_fire & ~src_known;
      if (slot_free && win_vld) begin
        m_a_valid   <= 1'b1;
        m_a_opcode  <= sel_opcode;
        m_a_param   <= sel_param;
        m_a_size    <= sel_size;
        m_a_source  <= TL_RS'(win);
        m_a_address <= sel_address;
        m_a_data    <= sel_data;
        m_a_mask    <= sel_mask;
        m_a_corrupt <= sel_corrupt;
        ptr         <= (win == PW'(NoC - 1)) ? '0 : win + PW'(1);
      end else if (m_a_ready) begin
        m_a_valid <= 1'b0;
      end
    end
  end

  // Outstanding counters; a simultaneous accept and response cancel out.
  always_ff @(posedge dma_clock_i) begin
    for (int i = 0; i < NoC; i++) begin
      if (dma_reset_i) begin
        cnt[i] <= 4'd0;
      end else if (grant[i] && !(d_fire && src_hit[i])) begin
        cnt[i] <= cnt[i] + 4'd1;
      end else if (!grant[i] && d_fire && src_hit[i] && cnt[i] != 4'd0) begin
        cnt[i] <= cnt[i] - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter with NoC=2, TL_RS=4, MAX_OUT=2.
module tb_dma_bus_arbiter;

  localparam int NoC = 2;
  localparam int TL_RS = 4;

  logic dma_clock_i = 1'b0;
  logic dma_reset_i;
  logic [3*NoC-1:0] s_a_opcode, s_a_param;
  logic [4*NoC-1:0] s_a_size, s_a_mask;
  logic [32*NoC-1:0] s_a_address, s_a_data;
  logic [NoC-1:0] s_a_corrupt, s_a_valid, s_a_ready;
  logic [3*NoC-1:0] s_d_opcode;
  logic [2*NoC-1:0] s_d_param;
  logic [4*NoC-1:0] s_d_size;
  logic [32*NoC-1:0] s_d_data;
  logic [NoC-1:0] s_d_denied, s_d_corrupt, s_d_valid, s_d_ready;
  logic [2:0] m_a_opcode, m_a_param;
  logic [3:0] m_a_size, m_a_mask;
  logic [TL_RS-1:0] m_a_source, m_d_source;
  logic [31:0] m_a_address, m_a_data, m_d_data;
  logic m_a_corrupt, m_a_valid, m_a_ready;
  logic [2:0] m_d_opcode;
  logic [1:0] m_d_param;
  logic [3:0] m_d_size;
  logic m_d_denied, m_d_corrupt, m_d_valid, m_d_ready;
  logic busy_o, drop_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 dma_clock_i = ~dma_clock_i;

  dma_bus_arbiter #(.NoC(NoC), .TL_RS(TL_RS), .MAX_OUT(2)) dut (
    .dma_clock_i(dma_clock_i), .dma_reset_i(dma_reset_i),
    .s_a_opcode(s_a_opcode), .s_a_param(s_a_param), .s_a_size(s_a_size),
    .s_a_address(s_a_address), .s_a_data(s_a_data), .s_a_mask(s_a_mask),
    .s_a_corrupt(s_a_corrupt), .s_a_valid(s_a_valid), .s_a_ready(s_a_ready),
    .s_d_opcode(s_d_opcode), .s_d_param(s_d_param), .s_d_size(s_d_size),
    .s_d_data(s_d_data), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
    .s_d_valid(s_d_valid), .s_d_ready(s_d_ready),
    .m_a_opcode(m_a_opcode), .m_a_param(m_a_param), .m_a_size(m_a_size),
    .m_a_source(m_a_source), .m_a_address(m_a_address), .m_a_data(m_a_data),
    .m_a_mask(m_a_mask), .m_a_corrupt(m_a_corrupt), .m_a_valid(m_a_valid),
    .m_a_ready(m_a_ready),
    .m_d_opcode(m_d_opcode), .m_d_param(m_d_param), .m_d_size(m_d_size),
    .m_d_source(m_d_source), .m_d_data(m_d_data), .m_d_denied(m_d_denied),
    .m_d_corrupt(m_d_corrupt), .m_d_valid(m_d_valid), .m_d_ready(m_d_ready),
    .busy_o(busy_o), .drop_o(drop_o)
  );

  task automatic step();
    @(posedge dma_clock_i);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [31:0] addr);
    s_a_valid[ch] = v;
    s_a_address[32*ch +: 32] = addr;
    s_a_data[32*ch +: 32] = ~addr;
    s_a_opcode[3*ch +: 3] = 3'd4;
    s_a_size[4*ch +: 4] = 4'd2;
    s_a_mask[4*ch +: 4] = 4'hf;
  endtask

  task automatic respond(input logic v, input logic [TL_RS-1:0] src);
    m_d_valid = v;
    m_d_source = src;
  endtask

  task automatic test_reset();
    dma_reset_i = 1'b1;
    step();
    step();
    dma_reset_i = 1'b0;
    #1;
    n_cmp++; if (m_a_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_a_valid got %b want 0", m_a_valid); end
    n_cmp++; if (m_a_address !== 32'h0) begin n_err++; $display("FAIL reset_m_a_address got %h want 0", m_a_address); end
    n_cmp++; if (m_a_source !== 4'h0) begin n_err++; $display("FAIL reset_m_a_source got %h want 0", m_a_source); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL reset_drop got %b want 0", drop_o); end
    n_cmp++; if (s_a_ready !== 2'b00) begin n_err++; $display("FAIL reset_s_a_ready got %b want 00", s_a_ready); end
  endtask

  task automatic test_single();
    set_ch(1, 1'b1, 32'h0000_1000);
    #1;
    n_cmp++; if (s_a_ready !== 2'b10) begin n_err++; $display("FAIL single_s_a_ready got %b want 10", s_a_ready); end
    step();
    set_ch(1, 1'b0, 32'h0);
    n_cmp++; if (m_a_valid !== 1'b1) begin n_err++; $display("FAIL single_m_a_valid got %b want 1", m_a_valid); end
    n_cmp++; if (m_a_source !== 4'd1) begin n_err++; $display("FAIL single_m_a_source got %h want 1", m_a_source); end
    n_cmp++; if (m_a_address !== 32'h0000_1000) begin n_err++; $display("FAIL single_m_a_address got %h want 00001000", m_a_address); end
    n_cmp++; if (m_a_data !== 32'hFFFF_EFFF) begin n_err++; $display("FAIL single_m_a_data got %h want ffffefff", m_a_data); end
    n_cmp++; if (m_a_opcode !== 3'd4) begin n_err++; $display("FAIL single_m_a_opcode got %h want 4", m_a_opcode); end
    m_a_ready = 1'b1;
    step();
    n_cmp++; if (m_a_valid !== 1'b0) begin n_err++; $display("FAIL single_drain got %b want 0", m_a_valid); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy_outstanding got %b want 1", busy_o); end
    m_d_data = 32'h0000_CAFE;
    respond(1'b1, 4'd1);
    #1;
    n_cmp++; if (s_d_valid !== 2'b10) begin n_err++; $display("FAIL single_s_d_valid got %b want 10", s_d_valid); end
    n_cmp++; if (m_d_ready !== 1'b1) begin n_err++; $display("FAIL single_m_d_ready got %b want 1", m_d_ready); end
    n_cmp++; if (s_d_data !== {2{32'h0000_CAFE}}) begin n_err++; $display("FAIL single_s_d_data got %h want broadcast cafe", s_d_data); end
    s_d_ready = 2'b01;
    #1;
    n_cmp++; if (m_d_ready !== 1'b0) begin n_err++; $display("FAIL single_m_d_ready_steer got %b want 0", m_d_ready); end
    s_d_ready = 2'b11;
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_done got %b want 0", busy_o); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_src;
    set_ch(0, 1'b1, 32'h100);
    set_ch(1, 1'b1, 32'h200);
    for (int k = 0; k < 4; k++) begin
      step();
      exp_src = 4'(k % 2);
      n_cmp++; if (m_a_valid !== 1'b1) begin n_err++; $display("FAIL fair_valid[%0d] got %b want 1", k, m_a_valid); end
      n_cmp++; if (m_a_source !== exp_src) begin n_err++; $display("FAIL fair_source[%0d] got %h want %h", k, m_a_source, exp_src); end
      respond(1'b1, m_a_source);
    end
    set_ch(0, 1'b0, 32'h0);
    set_ch(1, 1'b0, 32'h0);
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL fair_busy_done got %b want 0", busy_o); end
  endtask

  task automatic test_limit();
    set_ch(0, 1'b1, 32'h300);
    step();
    step();
    n_cmp++; if (s_a_ready !== 2'b00) begin n_err++; $display("FAIL limit_ch0_blocked got %b want 00", s_a_ready); end
    n_cmp++; if (m_a_source !== 4'd0) begin n_err++; $display("FAIL limit_second_source got %h want 0", m_a_source); end
    set_ch(1, 1'b1, 32'h400);
    #1;
    n_cmp++; if (s_a_ready !== 2'b10) begin n_err++; $display("FAIL limit_ch1_served got %b want 10", s_a_ready); end
    step();
    set_ch(1, 1'b0, 32'h0);
    n_cmp++; if (m_a_source !== 4'd1) begin n_err++; $display("FAIL limit_ch1_source got %h want 1", m_a_source); end
    respond(1'b1, 4'd0);
    #1;
    n_cmp++; if (s_a_ready !== 2'b00) begin n_err++; $display("FAIL limit_still_blocked got %b want 00", s_a_ready); end
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (s_a_ready !== 2'b01) begin n_err++; $display("FAIL limit_reopen got %b want 01", s_a_ready); end
    step();
    set_ch(0, 1'b0, 32'h0);
    n_cmp++; if (m_a_source !== 4'd0 || m_a_valid !== 1'b1) begin n_err++; $display("FAIL limit_regrant got src %h vld %b want src 0 vld 1", m_a_source, m_a_valid); end
    respond(1'b1, 4'd0);
    step();
    step();
    respond(1'b1, 4'd1);
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL limit_busy_done got %b want 0", busy_o); end
  endtask

  task automatic test_backpressure();
    m_a_ready = 1'b0;
    set_ch(0, 1'b1, 32'hA0);
    set_ch(1, 1'b1, 32'hA1);
    step();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (s_a_ready !== 2'b00) begin n_err++; $display("FAIL bp_s_a_ready[%0d] got %b want 00", k, s_a_ready); end
      n_cmp++; if (m_a_address !== 32'hA1 || m_a_source !== 4'd1 || m_a_valid !== 1'b1) begin
        n_err++; $display("FAIL bp_hold[%0d] got addr %h src %h vld %b want a1 1 1", k, m_a_address, m_a_source, m_a_valid);
      end
      step();
    end
    m_a_ready = 1'b1;
    #1;
    n_cmp++; if (s_a_ready !== 2'b01) begin n_err++; $display("FAIL bp_release_ready got %b want 01", s_a_ready); end
    step();
    set_ch(0, 1'b0, 32'h0);
    set_ch(1, 1'b0, 32'h0);
    n_cmp++; if (m_a_address !== 32'hA0 || m_a_source !== 4'd0 || m_a_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_refill got addr %h src %h vld %b want a0 0 1", m_a_address, m_a_source, m_a_valid);
    end
    respond(1'b1, 4'd1);
    step();
    respond(1'b1, 4'd0);
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL bp_busy_done got %b want 0", busy_o); end
  endtask

  task automatic test_unknown_source();
    set_ch(1, 1'b1, 32'h500);
    step();
    set_ch(1, 1'b0, 32'h0);
    step();
    s_d_ready = 2'b00;
    respond(1'b1, 4'd3);
    #1;
    n_cmp++; if (m_d_ready !== 1'b1) begin n_err++; $display("FAIL unk_m_d_ready got %b want 1", m_d_ready); end
    n_cmp++; if (s_d_valid !== 2'b00) begin n_err++; $display("FAIL unk_s_d_valid got %b want 00", s_d_valid); end
    n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL unk_drop_early got %b want 0", drop_o); end
    step();
    respond(1'b0, 4'd0);
    s_d_ready = 2'b11;
    n_cmp++; if (drop_o !== 1'b1) begin n_err++; $display("FAIL unk_drop_pulse got %b want 1", drop_o); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL unk_cnt_kept got busy %b want 1", busy_o); end
    step();
    n_cmp++; if (drop_o !== 1'b0) begin n_err++; $display("FAIL unk_drop_end got %b want 0", drop_o); end
    respond(1'b1, 4'd1);
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL unk_busy_done got %b want 0", busy_o); end
  endtask

  task automatic test_simultaneous_and_reset();
    set_ch(0, 1'b1, 32'h600);
    step();
    respond(1'b1, 4'd0);
    #1;
    n_cmp++; if (s_a_ready !== 2'b01) begin n_err++; $display("FAIL sim_s_a_ready got %b want 01", s_a_ready); end
    step();
    set_ch(0, 1'b0, 32'h0);
    respond(1'b0, 4'd0);
    step();
    n_cmp++; if (busy_o !== 1'b1 || m_a_valid !== 1'b0) begin n_err++; $display("FAIL sim_cnt_kept got busy %b vld %b want 1 0", busy_o, m_a_valid); end
    respond(1'b1, 4'd0);
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL sim_busy_done got %b want 0", busy_o); end
    set_ch(0, 1'b1, 32'h700);
    set_ch(1, 1'b1, 32'h800);
    step();
    step();
    dma_reset_i = 1'b1;
    step();
    dma_reset_i = 1'b0;
    set_ch(0, 1'b0, 32'h0);
    set_ch(1, 1'b0, 32'h0);
    #1;
    n_cmp++; if (m_a_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid got %b want 0", m_a_valid); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy got %b want 0", busy_o); end
    respond(1'b1, 4'd0);
    step();
    respond(1'b0, 4'd0);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_no_underflow got busy %b want 0", busy_o); end
  endtask

  initial begin
    dma_reset_i = 1'b1;
    s_a_opcode = '0; s_a_param = '0; s_a_size = '0; s_a_mask = '0;
    s_a_address = '0; s_a_data = '0; s_a_corrupt = '0; s_a_valid = '0;
    s_d_ready = 2'b11;
    m_a_ready = 1'b0;
    m_d_opcode = 3'd1; m_d_param = '0; m_d_size = 4'd2; m_d_source = '0;
    m_d_data = '0; m_d_denied = 1'b0; m_d_corrupt = 1'b0; m_d_valid = 1'b0;
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_limit();
    test_backpressure();
    test_unknown_source();
    test_simultaneous_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dma_bus_arbiter.md
# dma_bus_arbiter

Shares one TileLink-UL master port between the `NoC` per-channel master ports of the multi-channel DMA controller. A-channel requests are arbitrated round-robin, tagged with the channel index in `a_source`, and registered onto the shared port. D-channel responses are steered back to the owning channel by `d_source`. Per-channel outstanding counters cap the number of in-flight requests on each channel.

## Interface
Parameters:
- `NoC`, 2, number of DMA channels (≥1).
- `TL_RS`, 4, source width; must satisfy `TL_RS ≥ max(1, $clog2(NoC))`.
- `MAX_OUT`, 2, maximum outstanding requests per channel (1..15).

Ports:
- `dma_clock_i`  in  1  single clock; all logic on its rising edge.
- `dma_reset_i`  in  1  reset, synchronous, active-high.
- `s_a_opcode / s_a_param`  in  3·NoC each  per-channel A opcode/param; channel i in bits [3i+2:3i].
- `s_a_size`  in  4·NoC  per-channel A size.
- `s_a_address / s_a_data`  in  32·NoC each  per-channel A address/data.
- `s_a_mask`  in  4·NoC  per-channel A byte mask.
- `s_a_corrupt / s_a_valid`  in  NoC each  per-channel A corrupt/valid.
- `s_a_ready`  out  NoC  per-channel A ready.
- `s_d_opcode`  out  3·NoC  D opcode, broadcast to all channels.
- `s_d_param`  out  2·NoC  D param, broadcast.
- `s_d_size`  out  4·NoC  D size, broadcast.
- `s_d_data`  out  32·NoC  D data, broadcast.
- `s_d_denied / s_d_corrupt`  out  NoC each  D denied/corrupt, broadcast.
- `s_d_valid`  out  NoC  D valid, asserted only for the owning channel.
- `s_d_ready`  in  NoC  per-channel D ready.
- `m_a_opcode / m_a_param`  out  3 each  shared A opcode/param.
- `m_a_size`  out  4  shared A size.
- `m_a_source`  out  TL_RS  shared A source.
- `m_a_address / m_a_data`  out  32 each  shared A address/data.
- `m_a_mask`  out  4  shared A byte mask.
- `m_a_corrupt / m_a_valid`  out  1 each  shared A corrupt/valid.
- `m_a_ready`  in  1  shared A ready.
- `m_d_opcode`  in  3  shared D opcode.
- `m_d_param`  in  2  shared D param.
- `m_d_size`  in  4  shared D size.
- `m_d_source`  in  TL_RS  shared D source.
- `m_d_data`  in  32  shared D data.
- `m_d_denied / m_d_corrupt / m_d_valid`  in  1 each  shared D denied/corrupt/valid.
- `m_d_ready`  out  1  shared D ready.
- `busy_o`  out  1  any request buffered or outstanding.
- `drop_o`  out  1  one-cycle pulse when a response with an unknown source is discarded.

## Operation
- **Traffic model:** single-beat traffic only (size ≤ 2). Larger sizes are forwarded unchanged and are unsupported.
- **A slot:** a one-entry output register `slot`.
  - `slot_free = ~m_a_valid | m_a_ready`.
  - `elig[i] = s_a_valid[i] & (cnt[i] < MAX_OUT)`.
- **Arbitration:** when `slot_free` and any `elig` bit is set, the winner is the first eligible channel scanning `ptr, ptr+1, …` modulo NoC.
  - `s_a_ready[i] = slot_free & (i == winner)`. This is a one-hot or zero-hot vector. It does not depend on `s_a_valid[i]` beyond selecting the winner.
- **On winner handshake:**
  - `slot` loads all winner A fields.
  - `m_a_source` is loaded with the winner index, zero-extended to TL_RS.
  - `m_a_valid` is set to 1.
  - `ptr` becomes `(winner+1) mod NoC`.
- **No winner:** if there is no winner and `m_a_ready` is high, `m_a_valid` clears.
- **Counters:** `cnt[i]` is 4 bits.
  - Increment on an `s_a` handshake of channel i.
  - Decrement on an `m_d` handshake with `m_d_source == i`.
  - Both in the same cycle: unchanged.
  - Decrement saturates at 0.
- **D routing:** combinational.
  - `s_d_valid[i] = m_d_valid & (m_d_source == i)`.
  - `m_d_ready = s_d_ready[m_d_source]` when `m_d_source < NoC`.
  - Broadcast D fields carry `m_d_*` unchanged.
- **Unknown source:** when `m_d_source ≥ NoC`, `m_d_ready = 1`, no `s_d_valid` asserts, and `drop_o` pulses (registered, one cycle after the beat).
- **Status:** `busy_o = m_a_valid | (any cnt ≠ 0)`.

## Timing
- **Reset values:** `m_a_valid` 0, all other `m_a_*` 0, `ptr` 0, all `cnt` 0, `drop_o` 0. `s_a_ready` follows from these (channel 0 may win in the first cycle after reset).
- **A latency:** 1 cycle; handshake at cycle N gives `m_a_valid` at N+1.
- **A throughput:** 1 request per cycle while `m_a_ready` stays high.
- **A stall:** when `m_a_ready` is low and `m_a_valid` is high, `slot` holds and all `s_a_ready` are 0.
- **D path:** 0-cycle latency; ready and valid are purely combinational.
- **Reset mid-operation:** responses arriving after reset are routed normally. Counters saturate at 0, so they never underflow.
- **Fairness:** with all channels continuously valid and not at limit, grants rotate 0,1,…,NoC-1,0,…

## Test plan
- **Single request:** after reset, channel 1 issues a Get at 0x1000 → `m_a_valid` the next cycle with `m_a_source` = 1, `m_a_address` = 0x1000. A D response with source 1 asserts `s_d_valid` = 2'b10 and `cnt[1]` returns to 0.
- **Fairness:** NoC=2, both channels continuously valid, `m_a_ready` = 1, responses returned immediately → `m_a_source` sequence 0,1,0,1 with no idle cycle.
- **Outstanding limit:** MAX_OUT=2, no responses returned → channel 0 gets 2 grants, then `s_a_ready[0]` stays 0. Channel 1 is still served. One response with source 0 → channel 0 is granted the next cycle.
- **Backpressure:** `m_a_ready` held 0 for 5 cycles → `m_a_*` stable, `s_a_ready` = 0. On release, the slot drains and refills in the same cycle.
- **Unknown source:** `m_d_source` = 3 with NoC=2 → `m_d_ready` = 1, `s_d_valid` = 0, `drop_o` = 1 for exactly one cycle, counters unchanged.
- **Simultaneous accept and response on one channel:** an `s_a` accept on channel 0 and an `m_d` response with source 0 in the same cycle → `cnt[0]` unchanged. Reset asserted mid-burst → `m_a_valid` = 0 and `busy_o` = 0 the next cycle.
